// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: opcodes (common with the ALU),
// instruction field positions and the issue FSM state encoding.
package alu_issue_pkg;

  localparam logic [2:0] ALU_MOV = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 13;
  localparam int RD_MSB   = 12;
  localparam int RD_LSB   = 10;
  localparam int RA_MSB   = 9;
  localparam int RA_LSB   = 7;
  localparam int IMM_BIT  = 6;
  localparam int RB_MSB   = 5;
  localparam int RB_LSB   = 3;
  localparam int IMM6_MSB = 5;
  localparam int IMM6_LSB = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= ALU_OR);
  endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 8-entry register file: two operand read ports, a debug read port and one
// synchronous write port. Entry 0 is forced to zero, so r0 always reads 0.
module alu_issue_regfile #(
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        ra_addr,
  output logic [DWIDTH-1:0] ra_data,
  input  logic [2:0]        rb_addr,
  output logic [DWIDTH-1:0] rb_data,
  input  logic [2:0]        dbg_addr,
  output logic [DWIDTH-1:0] dbg_data,
  input  logic              we,
  input  logic [2:0]        wa,
  input  logic [DWIDTH-1:0] wd
);

  logic [DWIDTH-1:0] mem_q [8];
  logic [DWIDTH-1:0] mem_d [8];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (we) begin
      mem_d[wa] = wd;
    end
    mem_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (!rst_n) begin
        mem_q[i] <= '0;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign ra_data  = mem_q[ra_addr];
  assign rb_data  = mem_q[rb_addr];
  assign dbg_data = mem_q[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: accepts one instruction at a time, reads operands, pulses
// alu_en, then waits for the ALU result (or a timeout) and writes it back.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int DWIDTH  = 16,
  parameter int TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic              alu_en,
  output logic [2:0]        alu_func,
  output logic [DWIDTH-1:0] alu_a,
  output logic [DWIDTH-1:0] alu_b,
  input  logic              alu_en_out,
  input  logic [DWIDTH-1:0] alu_result,
  output logic              wb_valid,
  output logic [2:0]        wb_addr,
  output logic [DWIDTH-1:0] wb_data,
  output logic              err,
  input  logic [2:0]        dbg_addr,
  output logic [DWIDTH-1:0] dbg_data
);

  localparam int CW = $clog2(TIMEOUT + 1);

  // Handshake: an instruction transfers on a rising edge where instr_valid and
  // instr_ready are both 1; instr_ready is high exactly while the FSM is idle.

  state_e            state_q, state_d;
  logic              alu_en_q, alu_en_d;
  logic [2:0]        alu_func_q, alu_func_d;
  logic [DWIDTH-1:0] alu_a_q, alu_a_d;
  logic [DWIDTH-1:0] alu_b_q, alu_b_d;
  logic [2:0]        rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wb_valid_q, wb_valid_d;
  logic [2:0]        wb_addr_q, wb_addr_d;
  logic [DWIDTH-1:0] wb_data_q, wb_data_d;
  logic              err_q, err_d;

  logic              rf_we;
  logic [DWIDTH-1:0] ra_data, rb_data, imm_ext;
  logic [2:0]        op;

  assign op      = instr[OP_MSB:OP_LSB];
  assign imm_ext = {{(DWIDTH-6){1'b0}}, instr[IMM6_MSB:IMM6_LSB]};

  alu_issue_regfile #(.DWIDTH(DWIDTH)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_addr  (instr[RA_MSB:RA_LSB]),
    .ra_data  (ra_data),
    .rb_addr  (instr[RB_MSB:RB_LSB]),
    .rb_data  (rb_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .wa       (rd_q),
    .wd       (alu_result)
  );

  always_comb begin
    state_d    = state_q;
    alu_en_d   = 1'b0;
    alu_func_d = alu_func_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    err_d      = 1'b0;
    rf_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          if (op_legal(op)) begin
            alu_en_d   = 1'b1;
            alu_func_d = op;
            alu_a_d    = ra_data;
            alu_b_d    = instr[IMM_BIT] ? imm_ext : rb_data;
            rd_d       = instr[RD_MSB:RD_LSB];
            cnt_d      = '0;
            state_d    = ST_WAIT;
          end else begin
            // Illegal opcode is consumed and flagged; the ALU is never touched.
            err_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (alu_en_out) begin
          rf_we      = 1'b1;
          wb_valid_d = 1'b1;
          wb_addr_d  = rd_q;
          wb_data_d  = alu_result;
          state_d    = ST_IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      alu_en_q   <= 1'b0;
      alu_func_q <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_en_q   <= alu_en_d;
      alu_func_q <= alu_func_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign alu_en      = alu_en_q;
  assign alu_func    = alu_func_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign wb_valid    = wb_valid_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign err         = err_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural one-cycle ALU attached;
// outputs are sampled on the falling edge.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_ready;
  logic        alu_en;
  logic [2:0]  alu_func;
  logic [15:0] alu_a, alu_b;
  logic        alu_en_out = 1'b0;
  logic [15:0] alu_result = '0;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        err;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;

  logic        alu_mute = 1'b0;
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_q[$];

  alu_issue #(.DWIDTH(16), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_en      (alu_en),
    .alu_func    (alu_func),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_en_out  (alu_en_out),
    .alu_result  (alu_result),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .err         (err),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // clock
  always #5 clk = ~clk;

  // Behavioural ALU: samples en_in on a rising edge, result valid one cycle later.
  always @(posedge clk) begin
    if (alu_en && !alu_mute) begin
      alu_en_out <= 1'b1;
      case (alu_func)
        3'b000:  alu_result <= alu_b;
        3'b001:  alu_result <= alu_a + alu_b;
        3'b010:  alu_result <= alu_a - alu_b;
        3'b011:  alu_result <= alu_a & alu_b;
        default: alu_result <= alu_a | alu_b;
      endcase
    end else begin
      alu_en_out <= 1'b0;
    end
  end

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] ra, input logic imm,
                                      input logic [5:0] lo6);
    return {op, rd, ra, imm, lo6};
  endfunction

  function automatic logic [5:0] rb(input logic [2:0] r);
    return {r, 3'b000};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dbg_chk(input string tag, input logic [2:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  // Drive one legal instruction and check the two-cycle writeback timing.
  task automatic exec(input string tag, input logic [15:0] ins,
                      input logic [2:0] rd, input logic [15:0] data);
    logic [15:0] exp;
    exp_q.push_back(data);
    @(negedge clk);
    chk({tag, "_ready"}, {31'h0, instr_ready}, 32'd1);
    chk({tag, "_idle_wb"}, {31'h0, wb_valid}, 32'd0);
    instr_valid = 1'b1;
    instr = ins;
    @(negedge clk);
    instr_valid = 1'b0;
    chk({tag, "_alu_en"}, {31'h0, alu_en}, 32'd1);
    @(negedge clk);
    chk({tag, "_busy"}, {31'h0, instr_ready}, 32'd0);
    chk({tag, "_early_wb"}, {31'h0, wb_valid}, 32'd0);
    @(negedge clk);
    exp = exp_q.pop_front();
    chk({tag, "_wb_valid"}, {31'h0, wb_valid}, 32'd1);
    chk({tag, "_wb_addr"}, {29'h0, wb_addr}, {29'h0, rd});
    chk({tag, "_wb_data"}, {16'h0, wb_data}, {16'h0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, instr_ready}, 32'd1);
    chk("rst_alu_en", {31'h0, alu_en}, 32'd0);
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'd0);
    chk("rst_err", {31'h0, err}, 32'd0);
    chk("rst_alu_a", {16'h0, alu_a}, 32'd0);
    rst_n = 1'b1;

    // 1: MOV / ADD
    exec("mov_r1", enc(3'b000, 3'd1, 3'd0, 1'b1, 6'd5), 3'd1, 16'd5);
    exec("add_r2", enc(3'b001, 3'd2, 3'd1, 1'b0, rb(3'd1)), 3'd2, 16'd10);
    dbg_chk("dbg_r2", 3'd2, 16'd10);

    // 2: SUB wrap, AND/OR
    exec("mov_r3", enc(3'b000, 3'd3, 3'd0, 1'b1, 6'd1), 3'd3, 16'd1);
    exec("sub_r4", enc(3'b010, 3'd4, 3'd0, 1'b0, rb(3'd3)), 3'd4, 16'hFFFF);
    exec("mov_r6", enc(3'b000, 3'd6, 3'd0, 1'b1, 6'd63), 3'd6, 16'h003F);
    exec("add_r6a", enc(3'b001, 3'd6, 3'd6, 1'b0, rb(3'd6)), 3'd6, 16'h007E);
    exec("add_r6b", enc(3'b001, 3'd6, 3'd6, 1'b0, rb(3'd6)), 3'd6, 16'h00FC);
    exec("add_r6i", enc(3'b001, 3'd6, 3'd6, 1'b1, 6'd3), 3'd6, 16'h00FF);
    exec("and_r5", enc(3'b011, 3'd5, 3'd4, 1'b0, rb(3'd6)), 3'd5, 16'h00FF);
    exec("or_r5", enc(3'b100, 3'd5, 3'd4, 1'b0, rb(3'd6)), 3'd5, 16'hFFFF);
    dbg_chk("dbg_r5", 3'd5, 16'hFFFF);

    // 3: write to r0 reported but discarded
    exec("mov_r0", enc(3'b000, 3'd0, 3'd0, 1'b1, 6'd63), 3'd0, 16'd63);
    dbg_chk("dbg_r0", 3'd0, 16'd0);

    // 4: illegal opcode
    @(negedge clk);
    instr_valid = 1'b1;
    instr = enc(3'b110, 3'd7, 3'd1, 1'b0, 6'd0);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("ill_err", {31'h0, err}, 32'd1);
    chk("ill_alu_en", {31'h0, alu_en}, 32'd0);
    chk("ill_ready", {31'h0, instr_ready}, 32'd1);
    @(negedge clk);
    chk("ill_err_clear", {31'h0, err}, 32'd0);
    chk("ill_alu_en2", {31'h0, alu_en}, 32'd0);
    dbg_chk("ill_r7", 3'd7, 16'd0);

    // 5: timeout with the ALU silent
    alu_mute = 1'b1;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = enc(3'b001, 3'd7, 3'd1, 1'b1, 6'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    chk("to_alu_en", {31'h0, alu_en}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("to_err_early", {31'h0, err}, 32'd0);
      chk("to_busy", {31'h0, instr_ready}, 32'd0);
    end
    @(negedge clk);
    chk("to_err", {31'h0, err}, 32'd1);
    chk("to_no_wb", {31'h0, wb_valid}, 32'd0);
    chk("to_ready", {31'h0, instr_ready}, 32'd1);
    @(negedge clk);
    chk("to_err_clear", {31'h0, err}, 32'd0);
    dbg_chk("to_r7", 3'd7, 16'd0);
    alu_mute = 1'b0;

    // 6: reset the cycle after accept; the late ALU result must be ignored
    @(negedge clk);
    instr_valid = 1'b1;
    instr = enc(3'b000, 3'd7, 3'd0, 1'b1, 6'd9);
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    chk("mr_alu_en", {31'h0, alu_en}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mr_alu_en_off", {31'h0, alu_en}, 32'd0);
    chk("mr_ready", {31'h0, instr_ready}, 32'd1);
    @(negedge clk);
    chk("mr_no_wb", {31'h0, wb_valid}, 32'd0);
    chk("mr_no_err", {31'h0, err}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_chk("mr_rf_clear", 3'(i), 16'd0);
    end
    exec("post_rst", enc(3'b000, 3'd2, 3'd0, 1'b1, 6'd7), 3'd2, 16'd7);
    dbg_chk("post_rst_r2", 3'd2, 16'd7);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
